// File: rtl/ln_series_top.sv
// ln(1+x) by the alternating series x - x^2/2 + x^3/3 - ..., one term per clock, N_TERMS terms.
// Define LN_ROUND_EN to round both fixed-point products to nearest instead of truncating.
module ln_series_top #(
    parameter int unsigned N_TERMS = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] xBus,
    output logic [17:0] rBus,
    output logic        done,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIN  = 2'd2
    } state_t;

`ifdef LN_ROUND_EN
    localparam logic [31:0] RND = 32'h0000_8000;
`else
    localparam logic [31:0] RND = 32'h0000_0000;
`endif

    state_t             r_state;
    state_t             w_next;
    logic [15:0]        r_x;
    logic [15:0]        r_p;
    logic signed [19:0] r_acc;
    logic [3:0]         r_k;
    logic [17:0]        r_rbus;
    logic               r_done;

    logic               w_busy;
    logic               w_load;
    logic               w_step;
    logic               w_fin;
    logic               w_last;
    logic [15:0]        w_rom;
    logic [15:0]        w_term;
    logic [15:0]        w_p_next;
    logic signed [19:0] w_term_s;

    assign w_last = (r_k == 4'(N_TERMS));

    // floor(65536/k); k=1 bypasses the ROM because 1.0 does not fit in Q0.16
    always_comb begin
        case (r_k)
            4'd2:    w_rom = 16'd32768;
            4'd3:    w_rom = 16'd21845;
            4'd4:    w_rom = 16'd16384;
            4'd5:    w_rom = 16'd13107;
            4'd6:    w_rom = 16'd10922;
            4'd7:    w_rom = 16'd9362;
            4'd8:    w_rom = 16'd8192;
            4'd9:    w_rom = 16'd7281;
            4'd10:   w_rom = 16'd6553;
            4'd11:   w_rom = 16'd5957;
            4'd12:   w_rom = 16'd5461;
            4'd13:   w_rom = 16'd5041;
            4'd14:   w_rom = 16'd4681;
            4'd15:   w_rom = 16'd4369;
            default: w_rom = 16'd0;
        endcase
    end

    assign w_term   = (r_k == 4'd1) ? r_p
                                    : 16'((32'(r_p) * 32'(w_rom) + RND) >> 16);
    assign w_p_next = 16'((32'(r_p) * 32'(r_x) + RND) >> 16);
    assign w_term_s = $signed({4'b0000, w_term});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)  w_next = S_ITER;
            S_ITER:  if (w_last) w_next = S_FIN;
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = 1'b0;
        w_load = 1'b0;
        w_step = 1'b0;
        w_fin  = 1'b0;
        case (r_state)
            S_IDLE:  w_load = start;
            S_ITER:  begin w_busy = 1'b1; w_step = 1'b1; end
            S_FIN:   begin w_busy = 1'b1; w_fin  = 1'b1; end
            default: w_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x    <= '0;
            r_p    <= '0;
            r_acc  <= '0;
            r_k    <= '0;
            r_rbus <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_fin;
            if (w_load) begin
                r_x   <= xBus;
                r_p   <= xBus;
                r_acc <= '0;
                r_k   <= 4'd1;
            end
            if (w_step) begin
                // odd powers add, even powers subtract
                r_acc <= r_k[0] ? (r_acc + w_term_s) : (r_acc - w_term_s);
                r_p   <= w_p_next;
                r_k   <= r_k + 4'd1;
            end
            if (w_fin) r_rbus <= r_acc[17:0];
        end
    end

    assign rBus = r_rbus;
    assign done = r_done;
    assign busy = w_busy;

endmodule

// File: tb/tb_ln_series_top.sv
// Randomized and directed bench for ln_series_top against an arithmetic series model.
module tb_ln_series_top;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] xBus;
    logic [17:0] rBus;
    logic        done;
    logic        busy;
    logic [17:0] rBus1;
    logic        done1;
    logic        busy1;

    int n_chk  = 0;
    int n_pass = 0;
    bit acc_bad = 1'b0;

    ln_series_top #(.N_TERMS(8)) dut (
        .clk(clk), .rst(rst), .start(start), .xBus(xBus),
        .rBus(rBus), .done(done), .busy(busy)
    );

    ln_series_top #(.N_TERMS(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .xBus(xBus),
        .rBus(rBus1), .done(done1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (dut.r_acc[19:18] != 2'b00) acc_bad = 1'b1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    function automatic longint mulq(input longint a, input longint b);
`ifdef LN_ROUND_EN
        return (a * b + 32768) / 65536;
`else
        return (a * b) / 65536;
`endif
    endfunction

    // sum_{k=1..n} (-1)^(k+1) * x^k / k in Q0.16 fixed point
    function automatic logic [17:0] ln_model(input logic [15:0] x, input int n);
        longint pw = x;
        longint acc = 0;
        longint t;
        logic [63:0] a;
        for (int k = 1; k <= n; k++) begin
            t = (k == 1) ? pw : mulq(pw, 65536 / k);
            acc = (k % 2 == 1) ? acc + t : acc - t;
            pw = mulq(pw, x);
        end
        a = 64'(acc);
        return a[17:0];
    endfunction

    function automatic logic [31:0] near(input logic [17:0] got, input int ref_v);
        int d = int'(got) - ref_v;
        if (d < 0) d = -d;
        return (d <= 8) ? 32'd1 : 32'd0;
    endfunction

    task automatic send_start(input logic [15:0] x);
        start = 1'b1;
        xBus  = x;
        @(posedge clk);
        #1;
        start = 1'b0;
        xBus  = 16'($urandom);
    endtask

    task automatic wait_done(input int lat0, input logic [17:0] hold, output int lat, output bit bad);
        lat = lat0;
        bad = 1'b0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (!done && (!busy || rBus !== hold)) bad = 1'b1;
        end
    endtask

    task automatic run_op(input logic [15:0] x, output int lat, output bit bad);
        logic [17:0] old;
        old = rBus;
        send_start(x);
        wait_done(0, old, lat, bad);
    endtask

    initial begin
        int          lat;
        bit          bad;
        bit          seen;
        logic [17:0] old;
        logic [15:0] x;

        rst = 1'b1; start = 1'b0; xBus = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rbus", 32'(rBus), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_op(16'h0000, lat, bad);
        chk("x0_latency", lat, 9);
        chk("x0_result", 32'(rBus), 0);
        chk("x0_busy_hold", 32'(bad), 0);

        run_op(16'h8000, lat, bad);
        chk("xhalf_latency", lat, 9);
        chk("xhalf_result", 32'(rBus), 32'(ln_model(16'h8000, 8)));
        chk("xhalf_near", near(rBus, 26563), 1);
        chk("xhalf_busy_hold", 32'(bad), 0);
        @(posedge clk); #1;
        chk("xhalf_done_1cyc", 32'(done), 0);
        chk("xhalf_busy_after", 32'(busy), 0);

        run_op(16'hFFFF, lat, bad);
        chk("xmax_latency", lat, 9);
        chk("xmax_result", 32'(rBus), 32'(ln_model(16'hFFFF, 8)));
        chk("xmax_near", near(rBus, 41582), 1);
        @(posedge clk); #1;

        // second start while busy must be ignored
        old = rBus;
        send_start(16'h4000);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1; xBus = 16'h8000;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(3, old, lat, bad);
        chk("ign_latency", lat, 9);
        chk("ign_result", 32'(rBus), 32'(ln_model(16'h4000, 8)));
        chk("ign_near", near(rBus, 14624), 1);

        // back-to-back start in the done cycle
        old = rBus;
        send_start(16'h8000);
        chk("b2b_done_drop", 32'(done), 0);
        chk("b2b_busy", 32'(busy), 1);
        wait_done(0, old, lat, bad);
        chk("b2b_hold", 32'(bad), 0);
        chk("b2b_latency", lat, 9);
        chk("b2b_result", 32'(rBus), 32'(ln_model(16'h8000, 8)));

        // asynchronous reset in the 4th iteration
        send_start(16'hFFFF);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(busy), 0);
        chk("arst_rbus", 32'(rBus), 0);
        chk("arst_done", 32'(done), 0);
        #3;
        rst = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        chk("arst_no_done", 32'(seen), 0);
        chk("arst_rbus_after", 32'(rBus), 0);
        run_op(16'h8000, lat, bad);
        chk("arst_rerun_latency", lat, 9);
        chk("arst_rerun_result", 32'(rBus), 32'(ln_model(16'h8000, 8)));

        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            x = 16'($urandom);
            run_op(x, lat, bad);
            chk("rnd_latency", lat, 9);
            chk("rnd_result", 32'(rBus), 32'(ln_model(x, 8)));
            chk("rnd_n1_result", 32'(rBus1), 32'(x));
            chk("rnd_n1_idle", {30'd0, done1, busy1}, 0);
        end

        chk("acc_top_bits_zero", 32'(acc_bad), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ln_series_top.md
Name: ln_series_top

Overview:
- Natural-log companion to the exponential Maclaurin calculator: computes ln(1+x) with the alternating series x - x^2/2 + x^3/3 - ...
- Same start/done handshake and bus widths as the exp block, so the shared test harness and top-level sequencer can drive either block.
- Single module holding its own FSM and datapath (power register, reciprocal ROM, accumulator, term counter).

Parameters:
- N_TERMS, 8, number of series terms summed; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request pulse; sampled only in IDLE.
- xBus  input  16  operand x, unsigned Q0.16 (0 <= x < 1).
- rBus  output  18  result ln(1+x), unsigned Q2.16; holds the last result.
- done  output  1  one-cycle pulse, result valid on rBus.
- busy  output  1  high while in ITER or FIN.

Behaviour:
- Reset (async, any state): state goes to IDLE. rBus=0, done=0, busy=0; internal P, acc and k are cleared.
- Registers:
  - X: 16-bit latched operand.
  - P: 16-bit Q0.16, holds x^k.
  - acc: 20-bit signed Q3.16.
  - k: 4-bit term index.
- Reciprocal ROM: R[k] = floor(65536/k) for k=2..15; R[1] is treated as exact 1.0, so the term equals P.
- Product rule: (a*b)>>16, truncation toward zero. Both the term product P*R[k] and the power product P*X follow this rule.
- IDLE: busy=0. On an edge with start=1: X<=xBus, P<=xBus, acc<=0, k<=1, go to ITER.
- ITER, one term per cycle:
  - Odd k: acc<=acc+term(k). Even k: acc<=acc-term(k).
  - P<=(P*X)>>16, k<=k+1.
  - If k==N_TERMS, go to FIN instead of continuing.
- FIN, one cycle: rBus<=acc[17:0], done<=1, go to IDLE.
  - acc is provably in [0, 0.75) for legal x. No saturation logic is needed.
  - acc[19:18] must be 0. The bench asserts this.
- done is registered and high for exactly one cycle, during the cycle after the FIN edge.
- Latency: start sampled at edge E0. ITER occupies edges E1..E_N. The FIN edge is E_(N+1). done is high between E_(N+1) and E_(N+2). For N_TERMS=8 that is 9 cycles from start to done.
- start while busy=1 is ignored; no queuing. xBus changes after E0 have no effect.
- start=1 in the done-high cycle (state already IDLE) is accepted: the next operation begins, done drops at that edge, and rBus keeps the old value until the new FIN.
- x=0: P becomes 0 after the first product, so rBus=0.
- N_TERMS=1: one ITER cycle, rBus = x exactly.
- Reset asserted mid-operation: aborts the operation, no done pulse, rBus=0. After reset release, a new start must be issued.

Optional Feature:
- Macro: LN_ROUND_EN.
- Defined: both products round to nearest, computed as (a*b + 0x8000)>>16.
- Undefined: truncation as above.
- Latency, handshake and all other behaviour are identical in both builds.
- Expected results with the macro defined differ by at most ±N_TERMS LSB from the truncating build.

Test Plan:
- Reset then idle: rst pulse mid-cycle -> rBus=0, done=0, busy=0 immediately (asynchronous, no clock edge needed).
- x=0x0000, start, N_TERMS=8 -> done exactly 9 cycles after the start edge; rBus=0x00000.
- x=0x8000 (0.5) -> rBus within ±8 LSB of 26563 (0.405316, 8-term sum); done high exactly one cycle; busy low afterwards.
- x=0xFFFF -> rBus within ±8 LSB of 41582 (0.6345); acc[19:18]=0 throughout.
- Extra start pulses during busy, x=0x4000 then 0x8000 -> second pulse ignored; result matches x=0x4000 (within ±8 LSB of 14624); back-to-back start in the done cycle starts a new op and rBus holds until the new FIN.
- rst asserted at the 4th ITER cycle -> no done pulse, rBus=0; a fresh start afterwards with x=0x8000 yields the same result as the clean run.
